// File: rtl/extremum_tracker.sv
// ============================================================================
// extremum_tracker
// ----------------------------------------------------------------------------
// Multi-channel signed min/max tracker for an AXI-Stream sample feed.
// Over a window of 2^EF_log_count accepted beats every channel keeps a running
// minimum and maximum.  On the last beat of the window a pair of thresholds is
// derived per channel by pulling the extremes towards the window centre by a
// factor of 2^EF_shift.  The thresholds drive downstream fringe comparators.
//
// Parameters
//    SAMPLE_WIDTH   signed sample width of one channel
//    NUM_CHANNELS   number of channels packed side by side in S_AXIS_tdata
//    COUNT_WIDTH    beat counter width (EF_log_count must stay below it)
//
// Ports
//    aclk                 clock
//    areset               asynchronous active-high reset
//    EF_log_count         window length exponent, latched at window start
//    EF_shift             threshold contraction shift, latched at window start
//    EF_clear             single-cycle pulse aborting the current window
//    EF_lower_threshold   packed per-channel lower thresholds
//    EF_upper_threshold   packed per-channel upper thresholds
//    EF_update            one-cycle pulse after new thresholds are registered
//    EF_valid             sticky, set once the first window has completed
//    EF_clip              per-channel clip flag of the last completed window
//    S_AXIS_tvalid        input beat valid
//    S_AXIS_tdata         channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//    S_AXIS_tready        always 1, the tracker never stalls the stream
//
// Build option
//    EXTREMUM_TRACKER_CLIP_EN  when defined, EF_clip reports whether any
//    sample of the completed window sat at full scale; otherwise EF_clip is
//    tied low and no clip logic exists.
// ============================================================================
module extremum_tracker #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int NUM_CHANNELS = 2,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                                 aclk,
   input  logic                                 areset,
   input  logic [4:0]                           EF_log_count,
   input  logic [2:0]                           EF_shift,
   input  logic                                 EF_clear,
   output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] EF_lower_threshold,
   output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] EF_upper_threshold,
   output logic                                 EF_update,
   output logic                                 EF_valid,
   output logic [NUM_CHANNELS-1:0]              EF_clip,
   input  logic                                 S_AXIS_tvalid,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] S_AXIS_tdata,
   output logic                                 S_AXIS_tready
);

   // Two guard bits keep the centre and the contraction differences exact:
   // a sum of two samples needs one extra bit and the difference of a sample
   // and the centre never needs more than that.
   localparam int WIDE = SAMPLE_WIDTH + 2;

   typedef logic signed [SAMPLE_WIDTH-1:0] sampleT;
   typedef logic signed [WIDE-1:0]         wideT;

   localparam sampleT POS_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam sampleT NEG_MAX = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

   logic [COUNT_WIDTH-1:0] beatCount;
   logic [COUNT_WIDTH-1:0] finalCount;
   logic                   atFinalCount;
   logic [4:0]             logCountLatched;
   logic [2:0]             shiftLatched;
   logic                   paramsPending;
   logic [4:0]             effLogCount;
   logic [2:0]             effShift;
   logic                   updatePulse;
   logic                   validFlag;

   sampleT runMin    [NUM_CHANNELS];
   sampleT runMax    [NUM_CHANNELS];
   sampleT sampleIn  [NUM_CHANNELS];
   sampleT nextMin   [NUM_CHANNELS];
   sampleT nextMax   [NUM_CHANNELS];
   sampleT lowerCalc [NUM_CHANNELS];
   sampleT upperCalc [NUM_CHANNELS];
   sampleT lowerReg  [NUM_CHANNELS];
   sampleT upperReg  [NUM_CHANNELS];

   wideT wideMin   [NUM_CHANNELS];
   wideT wideMax   [NUM_CHANNELS];
   wideT centre    [NUM_CHANNELS];
   wideT lowerWide [NUM_CHANNELS];
   wideT upperWide [NUM_CHANNELS];

   // The tracker accepts every beat, so the stream is never back-pressured.
   assign S_AXIS_tready = 1'b1;

   // Window parameters are held in registers so that changes made while a
   // window is running only apply from the next window onwards.  Reset cannot
   // load a register from a live input, so it raises paramsPending instead:
   // until the first clock edge after reset the live inputs are used directly
   // and that edge copies them into the latches.
   always_comb begin
      effLogCount  = paramsPending ? EF_log_count : logCountLatched;
      effShift     = paramsPending ? EF_shift     : shiftLatched;
      finalCount   = (COUNT_ONE << effLogCount) - COUNT_ONE;
      atFinalCount = (beatCount == finalCount);
   end

   // Per channel: fold the incoming sample into the running extremes and,
   // from those folded values, work out the thresholds this window would
   // produce if the current beat were its last.  The centre uses an
   // arithmetic shift, so it rounds towards minus infinity, and the
   // contracted distances are shifted the same way.  Both results stay
   // between the folded min and max, so dropping the guard bits is lossless.
   always_comb begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         sampleIn[ch]  = S_AXIS_tdata[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         nextMin[ch]   = (sampleIn[ch] < runMin[ch]) ? sampleIn[ch] : runMin[ch];
         nextMax[ch]   = (sampleIn[ch] > runMax[ch]) ? sampleIn[ch] : runMax[ch];
         wideMin[ch]   = {{2{nextMin[ch][SAMPLE_WIDTH-1]}}, nextMin[ch]};
         wideMax[ch]   = {{2{nextMax[ch][SAMPLE_WIDTH-1]}}, nextMax[ch]};
         centre[ch]    = (wideMax[ch] + wideMin[ch]) >>> 1;
         lowerWide[ch] = centre[ch] + ((wideMin[ch] - centre[ch]) >>> effShift);
         upperWide[ch] = centre[ch] + ((wideMax[ch] - centre[ch]) >>> effShift);
         lowerCalc[ch] = lowerWide[ch][SAMPLE_WIDTH-1:0];
         upperCalc[ch] = upperWide[ch][SAMPLE_WIDTH-1:0];
      end
   end

   // Main window state.  A clear takes priority over everything, including a
   // beat that would have closed the window, and discards that beat.  An
   // accepted final beat registers the new thresholds, raises the update
   // pulse for exactly one cycle, and restarts the window on the same edge
   // with fresh sentinels and freshly latched parameters, so the very next
   // beat already belongs to the new window.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         beatCount       <= '0;
         logCountLatched <= '0;
         shiftLatched    <= '0;
         paramsPending   <= 1'b1;
         updatePulse     <= 1'b0;
         validFlag       <= 1'b0;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            runMin[ch]   <= POS_MAX;
            runMax[ch]   <= NEG_MAX;
            lowerReg[ch] <= POS_MAX;
            upperReg[ch] <= NEG_MAX;
         end
      end else begin
         updatePulse <= 1'b0;
         if (paramsPending) begin
            logCountLatched <= EF_log_count;
            shiftLatched    <= EF_shift;
            paramsPending   <= 1'b0;
         end
         if (EF_clear) begin
            beatCount <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
               runMin[ch] <= POS_MAX;
               runMax[ch] <= NEG_MAX;
            end
         end else if (S_AXIS_tvalid) begin
            if (atFinalCount) begin
               beatCount       <= '0;
               updatePulse     <= 1'b1;
               validFlag       <= 1'b1;
               logCountLatched <= EF_log_count;
               shiftLatched    <= EF_shift;
               for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                  runMin[ch]   <= POS_MAX;
                  runMax[ch]   <= NEG_MAX;
                  lowerReg[ch] <= lowerCalc[ch];
                  upperReg[ch] <= upperCalc[ch];
               end
            end else begin
               beatCount <= beatCount + COUNT_ONE;
               for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                  runMin[ch] <= nextMin[ch];
                  runMax[ch] <= nextMax[ch];
               end
            end
         end
      end
   end

   // Pack the per-channel threshold registers onto the flat output buses.
   always_comb begin
      EF_lower_threshold = '0;
      EF_upper_threshold = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         EF_lower_threshold[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lowerReg[ch];
         EF_upper_threshold[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH] = upperReg[ch];
      end
   end

   assign EF_update = updatePulse;
   assign EF_valid  = validFlag;

`ifdef EXTREMUM_TRACKER_CLIP_EN
   logic [NUM_CHANNELS-1:0] clipHit;
   logic [NUM_CHANNELS-1:0] clipWindow;
   logic [NUM_CHANNELS-1:0] clipReg;

   // A sample counts as clipped when it sits on either full-scale code.
   always_comb begin
      clipHit = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         clipHit[ch] = (sampleIn[ch] == POS_MAX) || (sampleIn[ch] == NEG_MAX);
      end
   end

   // clipWindow gathers hits over the running window and follows the same
   // clear/final-beat rules as the extremes.  The reported flag only changes
   // when a window completes, and it includes the closing sample.  A clear
   // forgets the partial window but leaves the reported flag alone.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         clipWindow <= '0;
         clipReg    <= '0;
      end else if (EF_clear) begin
         clipWindow <= '0;
      end else if (S_AXIS_tvalid) begin
         if (atFinalCount) begin
            clipReg    <= clipWindow | clipHit;
            clipWindow <= '0;
         end else begin
            clipWindow <= clipWindow | clipHit;
         end
      end
   end

   assign EF_clip = clipReg;
`else
   // Without clip tracking the port stays for interface compatibility.
   assign EF_clip = '0;
`endif

endmodule

// File: tb/tb_extremum_tracker.sv
// ============================================================================
// tb_extremum_tracker
// ----------------------------------------------------------------------------
// Bench for extremum_tracker with default parameters (16-bit, 2 channels).
// A table of hand-computed vectors covers the documented scenarios, a short
// hand-written sequence exercises reset in the middle of a window, and a long
// randomized run is compared against a window-level reference model that
// keeps the window samples in queues and evaluates the threshold formula
// with integer floor division.
// ============================================================================
module tb_extremum_tracker;

   localparam int SW   = 16;
   localparam int NC   = 2;
   localparam int PMAX = 32767;
   localparam int NMAX = -32768;

   logic              aclk = 1'b0;
   logic              areset;
   logic [4:0]        logCount;
   logic [2:0]        shiftIn;
   logic              clearIn;
   logic              tvalid;
   logic [NC*SW-1:0]  tdata;
   logic [NC*SW-1:0]  lowerOut;
   logic [NC*SW-1:0]  upperOut;
   logic              updateOut;
   logic              validOut;
   logic [NC-1:0]     clipOut;
   logic              treadyOut;

   int checkCount = 0;
   int failCount  = 0;

   extremum_tracker #(.SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC), .COUNT_WIDTH(32)) dut (
      .aclk               (aclk),
      .areset             (areset),
      .EF_log_count       (logCount),
      .EF_shift           (shiftIn),
      .EF_clear           (clearIn),
      .EF_lower_threshold (lowerOut),
      .EF_upper_threshold (upperOut),
      .EF_update          (updateOut),
      .EF_valid           (validOut),
      .EF_clip            (clipOut),
      .S_AXIS_tvalid      (tvalid),
      .S_AXIS_tdata       (tdata),
      .S_AXIS_tready      (treadyOut)
   );

   // Free-running 10-unit clock.
   always #5 aclk = ~aclk;

   typedef struct {
      bit        rst;
      int        lc;
      int        sh;
      bit        tv;
      bit        clr;
      int        d0;
      int        d1;
      int        el0;
      int        eu0;
      int        el1;
      int        eu1;
      bit        upd;
      bit        val;
      bit [1:0]  clp;
      string     tag;
   } VecT;

   VecT tbl[$];
   int  curLc;
   int  curSh;

   // ------------------------------------------------------------------------
   // Reference model state (window-level view)
   // ------------------------------------------------------------------------
   int       winQ0[$];
   int       winQ1[$];
   int       mL;
   int       mS;
   int       eL[NC];
   int       eU[NC];
   bit       eUpd;
   bit       eVal;
   bit [1:0] eClip;

   function automatic int floorDiv(int a, int d);
      int q;
      q = a / d;
      if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
      return q;
   endfunction

   function automatic void windowThresholds(input int q[$], input int s,
                                            output int lo, output int hi,
                                            output bit clipped);
      int mn;
      int mx;
      int c;
      mn = q[0];
      mx = q[0];
      clipped = 1'b0;
      foreach (q[i]) begin
         if (q[i] < mn) mn = q[i];
         if (q[i] > mx) mx = q[i];
         if (q[i] == PMAX || q[i] == NMAX) clipped = 1'b1;
      end
      c  = floorDiv(mn + mx, 2);
      lo = c + floorDiv(mn - c, 1 << s);
      hi = c + floorDiv(mx - c, 1 << s);
   endfunction

   function automatic void modelReset(int lc, int sh);
      winQ0.delete();
      winQ1.delete();
      mL = lc;
      mS = sh;
      for (int ch = 0; ch < NC; ch++) begin
         eL[ch] = PMAX;
         eU[ch] = NMAX;
      end
      eUpd  = 1'b0;
      eVal  = 1'b0;
      eClip = 2'b00;
   endfunction

   function automatic void modelStep(bit tv, bit clr, int d0, int d1, int lcNow, int shNow);
      bit c0;
      bit c1;
      eUpd = 1'b0;
      if (clr) begin
         winQ0.delete();
         winQ1.delete();
      end else if (tv) begin
         winQ0.push_back(d0);
         winQ1.push_back(d1);
         if (winQ0.size() == (1 << mL)) begin
            windowThresholds(winQ0, mS, eL[0], eU[0], c0);
            windowThresholds(winQ1, mS, eL[1], eU[1], c1);
            eClip = {c1, c0};
            eUpd  = 1'b1;
            eVal  = 1'b1;
            winQ0.delete();
            winQ1.delete();
            mL = lcNow;
            mS = shNow;
         end
      end
   endfunction

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   task automatic checkValue(string name, int actual, int expected);
      checkCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput(string tag, int el0, int eu0, int el1, int eu1,
                              bit upd, bit val, bit [1:0] clp);
      checkValue({tag, ".lower0"}, int'($signed(lowerOut[0*SW +: SW])), el0);
      checkValue({tag, ".upper0"}, int'($signed(upperOut[0*SW +: SW])), eu0);
      checkValue({tag, ".lower1"}, int'($signed(lowerOut[1*SW +: SW])), el1);
      checkValue({tag, ".upper1"}, int'($signed(upperOut[1*SW +: SW])), eu1);
      checkValue({tag, ".update"}, int'(updateOut), int'(upd));
      checkValue({tag, ".valid"},  int'(validOut),  int'(val));
      checkValue({tag, ".tready"}, int'(treadyOut), 1);
`ifdef EXTREMUM_TRACKER_CLIP_EN
      checkValue({tag, ".clip"},   int'(clipOut),   int'(clp));
`else
      checkValue({tag, ".clip"},   int'(clipOut),   0);
      if (clp != 2'b00) begin end
`endif
   endtask

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic applyStimulus(bit tv, bit clr, int d0, int d1);
      tvalid  = tv;
      clearIn = clr;
      tdata   = {16'(d1), 16'(d0)};
      @(posedge aclk);
      #1;
   endtask

   task automatic assertReset(int lc, int sh);
      areset   = 1'b1;
      logCount = 5'(lc);
      shiftIn  = 3'(sh);
      tvalid   = 1'b0;
      clearIn  = 1'b0;
      tdata    = '0;
      #1;
   endtask

   task automatic releaseReset();
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   function automatic void addReset(string tag, int lc, int sh);
      curLc = lc;
      curSh = sh;
      tbl.push_back('{rst:1'b1, lc:lc, sh:sh, tv:1'b0, clr:1'b0, d0:0, d1:0,
                      el0:PMAX, eu0:NMAX, el1:PMAX, eu1:NMAX,
                      upd:1'b0, val:1'b0, clp:2'b00, tag:tag});
   endfunction

   function automatic void addRow(string tag, bit tv, bit clr, int d0, int d1,
                                  int el0, int eu0, int el1, int eu1,
                                  bit upd, bit val, bit [1:0] clp);
      tbl.push_back('{rst:1'b0, lc:curLc, sh:curSh, tv:tv, clr:clr, d0:d0, d1:d1,
                      el0:el0, eu0:eu0, el1:el1, eu1:eu1,
                      upd:upd, val:val, clp:clp, tag:tag});
   endfunction

   function automatic int randSample();
      int       r;
      logic [15:0] v;
      r = int'($urandom_range(0, 19));
      if (r == 0) return NMAX;
      if (r == 1) return PMAX;
      v = 16'($urandom);
      return int'($signed(v));
   endfunction

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      areset   = 1'b1;
      logCount = '0;
      shiftIn  = '0;
      clearIn  = 1'b0;
      tvalid   = 1'b0;
      tdata    = '0;
      $display("[TB] extremum_tracker bench starting");

      // Scenario A: L=2, S=0, full-range thresholds.
      addReset("A.reset", 2, 0);
      addRow("A.b1",  1, 0, 10, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("A.b2",  1, 0, -5, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("A.b3",  1, 0,  3, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("A.b4",  1, 0,  7, 0, -5, 10, 0, 0, 1, 1, 2'b00);
      addRow("A.idle",0, 0,  0, 0, -5, 10, 0, 0, 0, 1, 2'b00);
      // Scenario B: same beats, S=1 contracts towards c=2.
      addReset("B.reset", 2, 1);
      addRow("B.b1",  1, 0, 10, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("B.b2",  1, 0, -5, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("B.b3",  1, 0,  3, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("B.b4",  1, 0,  7, 0, -2, 6, 0, 0, 1, 1, 2'b00);
      addRow("B.idle",0, 0,  0, 0, -2, 6, 0, 0, 0, 1, 2'b00);
      // Scenario C: idle cycles carrying full-scale data must be ignored.
      addReset("C.reset", 2, 0);
      addRow("C.b1",  1, 0, 10, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("C.g1",  0, 0, NMAX, NMAX, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("C.b2",  1, 0, -5, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("C.g2",  0, 0, NMAX, NMAX, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("C.b3",  1, 0,  3, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("C.g3",  0, 0, NMAX, NMAX, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("C.b4",  1, 0,  7, 0, -5, 10, 0, 0, 1, 1, 2'b00);
      addRow("C.g4",  0, 0, NMAX, NMAX, -5, 10, 0, 0, 0, 1, 2'b00);
      // Scenario D: L=0 makes every beat a window; S has no effect on one sample.
      addReset("D.reset", 0, 3);
      addRow("D.b1",  1, 0,  100, 0,  100,  100, 0, 0, 1, 1, 2'b00);
      addRow("D.idle1",0,0,    0, 0,  100,  100, 0, 0, 0, 1, 2'b00);
      addRow("D.b2",  1, 0, -200, 0, -200, -200, 0, 0, 1, 1, 2'b00);
      addRow("D.idle2",0,0,    0, 0, -200, -200, 0, 0, 0, 1, 2'b00);
      // Scenario E: full-scale extremes, floor of the centre, clip reporting.
      addReset("E.reset", 1, 0);
      addRow("E.b1",  1, 0, NMAX, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("E.b2",  1, 0, PMAX, 0, NMAX, PMAX, 0, 0, 1, 1, 2'b01);
      addRow("E.idle",0, 0,    0, 0, NMAX, PMAX, 0, 0, 0, 1, 2'b01);
      addRow("E.b3",  1, 0,    5, 0, NMAX, PMAX, 0, 0, 0, 1, 2'b01);
      addRow("E.b4",  1, 0,    6, 0,    5,    6, 0, 0, 1, 1, 2'b00);
      // Scenario F: clear mid-window, then clear colliding with a final beat.
      addReset("F.reset", 2, 0);
      addRow("F.b1",  1, 0, 50, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("F.b2",  1, 0, 60, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("F.clr", 1, 1, 99, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("F.c1",  1, 0,  1, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("F.c2",  1, 0,  2, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("F.c3",  1, 0,  3, 0, PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      addRow("F.c4",  1, 0,  4, 0,  1, 4, 0, 0, 1, 1, 2'b00);
      addRow("F.g1",  1, 0, 20, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.g2",  1, 0, 21, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.g3",  1, 0, 22, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.gclr",1, 1, 99, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.h1",  1, 0,  5, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.h2",  1, 0,  6, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.h3",  1, 0,  7, 0,  1, 4, 0, 0, 0, 1, 2'b00);
      addRow("F.h4",  1, 0,  8, 0,  5, 8, 0, 0, 1, 1, 2'b00);

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            assertReset(tbl[i].lc, tbl[i].sh);
            checkOutput(tbl[i].tag, tbl[i].el0, tbl[i].eu0, tbl[i].el1, tbl[i].eu1,
                        tbl[i].upd, tbl[i].val, tbl[i].clp);
            releaseReset();
         end else begin
            logCount = 5'(tbl[i].lc);
            shiftIn  = 3'(tbl[i].sh);
            applyStimulus(tbl[i].tv, tbl[i].clr, tbl[i].d0, tbl[i].d1);
            checkOutput(tbl[i].tag, tbl[i].el0, tbl[i].eu0, tbl[i].el1, tbl[i].eu1,
                        tbl[i].upd, tbl[i].val, tbl[i].clp);
         end
      end

      // Reset in the middle of a window after a completed window: everything
      // returns to reset values at once, and no update pulse follows.
      assertReset(2, 0);
      releaseReset();
      applyStimulus(1, 0, 10, 1);
      applyStimulus(1, 0, -5, 2);
      applyStimulus(1, 0,  3, 3);
      applyStimulus(1, 0,  7, 4);
      checkOutput("R.window", -5, 10, 1, 4, 1, 1, 2'b00);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 2, 0);
      applyStimulus(1, 0, 3, 0);
      #2;
      areset = 1'b1;
      #1;
      checkOutput("R.async", PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      @(posedge aclk);
      #1;
      checkOutput("R.held", PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);
      tvalid = 1'b0;
      areset = 1'b0;
      applyStimulus(0, 0, 0, 0);
      checkOutput("R.after", PMAX, NMAX, PMAX, NMAX, 0, 0, 2'b00);

      // Randomized run against the window-level reference model.
      assertReset(int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
      modelReset(int'(logCount), int'(shiftIn));
      checkOutput("rnd.reset", eL[0], eU[0], eL[1], eU[1], eUpd, eVal, eClip);
      releaseReset();
      for (int i = 0; i < 3000; i++) begin
         bit tv;
         bit clr;
         int d0;
         int d1;
         tv  = ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 49) == 0);
         d0  = randSample();
         d1  = randSample();
         if (i > 0 && $urandom_range(0, 19) == 0) begin
            logCount = 5'($urandom_range(0, 4));
            shiftIn  = 3'($urandom_range(0, 7));
         end
         applyStimulus(tv, clr, d0, d1);
         modelStep(tv, clr, d0, d1, int'(logCount), int'(shiftIn));
         checkOutput("rnd", eL[0], eU[0], eL[1], eU[1], eUpd, eVal, eClip);
      end

      tvalid  = 1'b0;
      clearIn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/extremum_tracker.md
Name: extremum_tracker

Overview:
- Multi-channel, parametrised successor to the single-channel extremum finder.
- Tracks the signed min/max of every channel over a window of 2^EF_log_count accepted AXIS beats.
- Derives per-channel lower/upper thresholds scaled towards the window centre.
- Sits after the ADC/filter stream; thresholds feed downstream comparators (fringe counting).

Parameters:
- SAMPLE_WIDTH, 16, signed sample width per channel.
- NUM_CHANNELS, 2, number of channels packed in tdata.
- COUNT_WIDTH, 32, beat counter width; EF_log_count must stay below COUNT_WIDTH.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- EF_log_count  in  5  window length = 2^EF_log_count beats; latched at window start.
- EF_shift  in  3  threshold contraction shift; latched at window start.
- EF_clear  in  1  single-cycle pulse; aborts the current window.
- EF_lower_threshold  out  NUM_CHANNELS*SAMPLE_WIDTH  packed per-channel lower threshold.
- EF_upper_threshold  out  NUM_CHANNELS*SAMPLE_WIDTH  packed per-channel upper threshold.
- EF_update  out  1  one-cycle pulse when thresholds change.
- EF_valid  out  1  sticky; high once the first window completes.
- EF_clip  out  NUM_CHANNELS  per-channel clip flag (optional feature).
- S_AXIS_tvalid  in  1  input beat valid.
- S_AXIS_tdata  in  NUM_CHANNELS*SAMPLE_WIDTH  channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- S_AXIS_tready  out  1  constant 1.

Behaviour:
- Reset is asynchronous and active-high (areset), clocked by aclk. On reset:
  - every lower threshold = +max (0111..1); every upper threshold = −max (1000..0);
  - EF_update=0, EF_valid=0, EF_clip=0, count=0;
  - running min/max at sentinels (running min = +max, running max = −max); window parameters re-latched from inputs.
- Beat accepted = S_AXIS_tvalid (tready always 1). Cycles with tvalid=0 change nothing.
- There is no idle state. Per accepted beat, each channel updates run_min = min(run_min, x) and run_max = max(run_max, x); count increments.
- Final beat (count == 2^L−1, L = latched log_count):
  - thresholds are computed including this beat's sample;
  - outputs are registered on that same clock edge;
  - EF_update is high in the following cycle only; EF_valid is set.
  - In the same edge: count=0, run_min/run_max return to sentinels, and EF_log_count/EF_shift are re-latched. The next beat starts the new window, so no samples are dropped.
- Arithmetic per channel, using SAMPLE_WIDTH+2-bit signed intermediates:
  - c = (run_max' + run_min') >>> 1, floor toward −inf;
  - lower = c + ((run_min' − c) >>> S);
  - upper = c + ((run_max' − c) >>> S);
  - primes denote values including the final beat. Results always lie in [run_min', run_max'] and are truncated to SAMPLE_WIDTH without overflow.
- L=0: every beat is a complete window. With S=0, lower = upper = sample; EF_update is high in each cycle after an accepted beat.
- EF_clear: count=0 and run_min/run_max return to sentinels; thresholds and EF_valid are retained.
  - Clear in the same cycle as a final beat: clear wins, no update, and that beat is discarded.
  - Clear with tvalid on a non-final beat: the beat is discarded.
- EF_log_count/EF_shift changes mid-window take effect at the next window start.
- Reset mid-window: immediate return to the reset state; the partial window is discarded.

Optional Feature:
- Macro: EXTREMUM_TRACKER_CLIP_EN.
- Defined:
  - per channel, a sticky in-window flag is set when any accepted sample equals −2^(SW−1) or 2^(SW−1)−1;
  - the flag is transferred to EF_clip on the final-beat edge (including the final sample) and cleared for the next window;
  - EF_clear clears the in-window flag only; reset clears both.
- Undefined: EF_clip is tied to 0 and no clip logic is built; the port is kept for interface stability.

Test Plan:
- SW=16, NC=2, L=2, S=0; ch0 beats 10,−5,3,7 (ch1 all 0) -> after 4th beat ch0 lower=−5, upper=10; ch1 lower=upper=0; EF_update one cycle; EF_valid=1.
- Same stimulus with S=1 -> c=2, ch0 lower=−2, upper=6.
- Same beats with tvalid=0 cycles interleaved carrying −32768 in tdata -> results identical to scenario 1; EF_clip=0.
- L=0, S=3; beats 100 then −200 -> after each beat lower=upper=sample; EF_update pulses twice.
- L=1, S=0; ch0 beats −32768, 32767 -> c=−1, lower=−32768, upper=32767; with CLIP_EN, EF_clip[0]=1 for that window and 0 after the next clean window.
- Mid-window EF_clear after 2 of 4 beats, then 4 beats 1,2,3,4 -> lower=1, upper=4. Separately, assert areset after 3 beats -> all outputs return to reset values immediately, with no update pulse.
